// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC register write port, runs the imem
// request/ready handshake and feeds IF/ID through a one-entry hold buffer.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_BOOT  | reset/boot: reload RESET_PC into the PC register, no request
// S_FETCH | request outstanding at PC; redirects arriving early are queued
// S_HOLD  | fetched word parked because IF/ID stalled; no request
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC,
  output logic        isPCWrite,
  output logic [31:0] data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_pend_valid;
  logic [31:0] r_pend_target;
  logic [31:0] r_hold_inst;
  logic [31:0] r_hold_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic        w_pc_write;
  logic        w_req;
  logic        w_deliver;
  logic [31:0] w_deliver_inst;
  logic [31:0] w_deliver_pc;
  logic        w_pend_set;
  logic        w_pend_clr;
  logic        w_hold_load;

  assign w_pc_plus4 = PC + 32'd4;

  always_comb begin
    w_next_state   = r_state;
    w_pc_write     = 1'b0;
    w_pc_next      = w_pc_plus4;
    w_req          = 1'b0;
    w_deliver      = 1'b0;
    w_deliver_inst = imem_rdata;
    w_deliver_pc   = PC;
    w_pend_set     = 1'b0;
    w_pend_clr     = 1'b0;
    w_hold_load    = 1'b0;

    case (r_state)
      S_BOOT: begin
        w_pc_write   = 1'b1;
        w_pc_next    = RESET_PC;
        w_next_state = S_FETCH;
      end

      S_FETCH: begin
        w_req = 1'b1;
        if (!imem_ready) begin
          // PC must not move while the request is outstanding
          w_pend_set = redirect_valid;
        end else if (redirect_valid || r_pend_valid) begin
          w_pc_write = 1'b1;
          w_pc_next  = redirect_valid ? redirect_target : r_pend_target;
          w_pend_clr = 1'b1;
        end else if (!stall) begin
          w_deliver  = 1'b1;
          w_pc_write = 1'b1;
        end else begin
          w_hold_load  = 1'b1;
          w_next_state = S_HOLD;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          w_pc_write   = 1'b1;
          w_pc_next    = redirect_target;
          w_next_state = S_FETCH;
        end else if (!stall) begin
          w_deliver      = 1'b1;
          w_deliver_inst = r_hold_inst;
          w_deliver_pc   = r_hold_pc;
          w_pc_write     = 1'b1;
          w_next_state   = S_FETCH;
        end
      end

      default: begin
        w_next_state = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A newer redirect overwrites an older one still waiting for the word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'd0;
    end else if (w_pend_clr) begin
      r_pend_valid <= 1'b0;
    end else if (w_pend_set) begin
      r_pend_valid  <= 1'b1;
      r_pend_target <= redirect_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_inst <= 32'd0;
      r_hold_pc   <= 32'd0;
    end else if (w_hold_load) begin
      r_hold_inst <= imem_rdata;
      r_hold_pc   <= PC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst       <= 32'd0;
      r_inst_pc    <= 32'd0;
      r_inst_valid <= 1'b0;
    end else begin
      r_inst_valid <= w_deliver;
      if (w_deliver) begin
        r_inst    <= w_deliver_inst;
        r_inst_pc <= w_deliver_pc;
      end
    end
  end

  assign isPCWrite  = w_pc_write;
  assign data       = w_pc_next & 32'hFFFF_FFFC;
  assign imem_req   = w_req;
  assign imem_addr  = PC;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = r_inst_valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: PC register and imem live here; directed table of
// the boot/wait/redirect/hold/wrap scenarios, then random traffic vs a model.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_q;
  logic        isPCWrite;
  logic [31:0] data;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .PC              (pc_q),
    .isPCWrite       (isPCWrite),
    .data            (data),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_valid      (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External PC register with no reset of its own; the sequencer loads it
  always @(posedge clk) if (isPCWrite) pc_q <= data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        stl;
    logic        rv;
    logic [31:0] rt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_wr;
    logic [31:0] e_data;
    logic        e_valid;
    logic [31:0] e_ipc;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic stl, input logic rv,
                              input logic [31:0] rt, input logic e_req,
                              input logic [31:0] e_addr, input logic e_wr,
                              input logic [31:0] e_data, input logic e_valid,
                              input logic [31:0] e_ipc);
    vec_t v;
    v.ready = rdy; v.stl = stl; v.rv = rv; v.rt = rt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_wr = e_wr; v.e_data = e_data;
    v.e_valid = e_valid; v.e_ipc = e_ipc;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_wr", {31'd0, isPCWrite}, 32'd1);
    chk("rst_data", data, RESET_PC);
    chk("rst_pc", pc_q, RESET_PC);
  endtask

  vec_t vecs[19];

  // Random-phase reference state: what the fetch unit currently owes
  bit          m_boot, m_held, m_owe;
  logic [31:0] m_pc, m_hpc, m_tgt, m_last_inst, m_last_pc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pc_q = 32'd0;
    vecs[0]  = mk(1,0,0,0,            0,32'h3000,    1,32'h3000,    0,0);
    vecs[1]  = mk(1,0,0,0,            1,32'h3000,    1,32'h3004,    1,32'h3000);
    vecs[2]  = mk(0,0,0,0,            1,32'h3004,    0,0,           0,0);
    vecs[3]  = mk(0,0,0,0,            1,32'h3004,    0,0,           0,0);
    vecs[4]  = mk(0,0,0,0,            1,32'h3004,    0,0,           0,0);
    vecs[5]  = mk(1,0,0,0,            1,32'h3004,    1,32'h3008,    1,32'h3004);
    vecs[6]  = mk(0,0,1,32'h4000,     1,32'h3008,    0,0,           0,0);
    vecs[7]  = mk(0,0,1,32'h5000,     1,32'h3008,    0,0,           0,0);
    vecs[8]  = mk(1,0,0,0,            1,32'h3008,    1,32'h5000,    0,0);
    vecs[9]  = mk(1,0,1,32'h300C,     1,32'h5000,    1,32'h300C,    0,0);
    vecs[10] = mk(1,1,0,0,            1,32'h300C,    0,0,           0,0);
    vecs[11] = mk(1,1,0,0,            0,32'h300C,    0,0,           0,0);
    vecs[12] = mk(1,1,0,0,            0,32'h300C,    0,0,           0,0);
    vecs[13] = mk(1,0,0,0,            0,32'h300C,    1,32'h3010,    1,32'h300C);
    vecs[14] = mk(1,1,0,0,            1,32'h3010,    0,0,           0,0);
    vecs[15] = mk(1,0,1,32'h6002,     0,32'h3010,    1,32'h6000,    0,0);
    vecs[16] = mk(1,0,1,32'hFFFF_FFFC,1,32'h6000,    1,32'hFFFF_FFFC,0,0);
    vecs[17] = mk(1,0,0,0,            1,32'hFFFF_FFFC,1,32'h0,      1,32'hFFFF_FFFC);
    vecs[18] = mk(0,0,0,0,            1,32'h0,       0,0,           0,0);

    do_reset();
    for (int i = 0; i < 19; i++) begin
      if (i != 0) @(negedge clk);
      rst_n = 1'b1;
      imem_ready = vecs[i].ready; stall = vecs[i].stl;
      redirect_valid = vecs[i].rv; redirect_target = vecs[i].rt;
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_wr", i), {31'd0, isPCWrite}, {31'd0, vecs[i].e_wr});
      if (vecs[i].e_wr) chk($sformatf("v%0d_data", i), data, vecs[i].e_data);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].e_ipc);
        chk($sformatf("v%0d_inst", i), inst, mem_word(vecs[i].e_ipc));
      end
    end

    // Reset while the request at PC=0 is still outstanding
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_wr", {31'd0, isPCWrite}, 32'd1);
    chk("midrst_data", data, RESET_PC);
    chk("midrst_inst_pc", inst_pc, 32'd0);
    imem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_pc", pc_q, RESET_PC);
    chk("midrst_valid", {31'd0, inst_valid}, 32'd0);

    // Random traffic against the reference
    do_reset();
    m_boot = 1; m_held = 0; m_owe = 0; m_pc = RESET_PC;
    m_hpc = 0; m_tgt = 0; m_last_inst = 0; m_last_pc = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        e_req, e_wr, e_del;
      logic [31:0] e_data, e_dpc;
      if (c != 0) @(negedge clk);
      rst_n = 1'b1;
      imem_ready = ($urandom_range(0, 2) != 0);
      stall = ($urandom_range(0, 2) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15)
                                                    : $urandom;
      #1;
      e_req = 0; e_wr = 0; e_data = 0; e_del = 0; e_dpc = 0;
      if (m_boot) begin
        e_wr = 1; e_data = RESET_PC;
      end else if (!m_held) begin
        e_req = 1;
        if (!imem_ready) begin
          if (redirect_valid) begin m_owe = 1; m_tgt = redirect_target; end
        end else if (redirect_valid || m_owe) begin
          e_wr = 1;
          e_data = redirect_valid ? redirect_target : m_tgt;
          e_data[1:0] = 2'b00;
          m_owe = 0;
        end else if (!stall) begin
          e_del = 1; e_dpc = m_pc; e_wr = 1; e_data = m_pc + 32'd4;
        end else begin
          m_held = 1; m_hpc = m_pc;
        end
      end else begin
        if (redirect_valid) begin
          m_held = 0; e_wr = 1; e_data = {redirect_target[31:2], 2'b00};
        end else if (!stall) begin
          m_held = 0; e_del = 1; e_dpc = m_hpc; e_wr = 1; e_data = m_pc + 32'd4;
        end
      end
      m_boot = 0;

      chk("rnd_pc", pc_q, m_pc);
      chk("rnd_addr", imem_addr, m_pc);
      chk("rnd_req", {31'd0, imem_req}, {31'd0, e_req});
      chk("rnd_wr", {31'd0, isPCWrite}, {31'd0, e_wr});
      if (e_wr) begin
        chk("rnd_data", data, e_data);
        m_pc = e_data;
      end
      if (e_del) begin
        m_last_pc = e_dpc; m_last_inst = mem_word(e_dpc);
      end
      @(posedge clk);
      #1;
      chk("rnd_valid", {31'd0, inst_valid}, {31'd0, e_del});
      chk("rnd_inst_pc", inst_pc, m_last_pc);
      chk("rnd_inst", inst, m_last_inst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the PC register's write side, i.e. its `isPCWrite` and `data` inputs, and runs the instruction-memory fetch handshake.
- Consumes the current `PC` value and decides each cycle whether the PC advances by 4, jumps to a redirect target, holds, or reloads the reset vector.
- Presents fetched words with their PC to the IF/ID register and absorbs IF/ID back-pressure with a one-entry hold buffer.

Parameters:
- RESET_PC, 32'h0000_3000, boot/reset fetch address.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- PC  input  32  current PC from the PC register.
- isPCWrite  output  1  PC register write enable; combinational (Mealy).
- data  output  32  next PC value for the PC register; combinational.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals PC.
- imem_ready  input  1  imem returns a word this cycle; valid only while imem_req=1.
- imem_rdata  input  32  fetched instruction word.
- stall  input  1  IF/ID cannot accept an instruction this cycle.
- redirect_valid  input  1  taken branch or jump from a later stage.
- redirect_target  input  32  redirect PC.
- inst  output  32  registered instruction to IF/ID.
- inst_pc  output  32  registered PC of inst.
- inst_valid  output  1  registered one-cycle qualifier for inst/inst_pc.

Behaviour:
- Reset (rst_n=0, asynchronous)
  - state=BOOT; inst=0, inst_pc=0, inst_valid=0.
  - Hold buffer and pending redirect are cleared.
  - While in BOOT, isPCWrite=1, data=RESET_PC and imem_req=0, so the PC is reloaded on every edge during reset.
- States: BOOT, FETCH, HOLD.
- BOOT:
  - The first clock edge after rst_n rises moves to FETCH.
  - isPCWrite=1 with data=RESET_PC on that edge too.
- FETCH, imem_req=1, imem_addr=PC:
  - imem_ready=0: isPCWrite=0; the PC must stay stable while the request is outstanding.
  - imem_ready=0 and redirect_valid=1: latch the target into pending. A later redirect overwrites pending.
  - imem_ready=1 and (redirect_valid or pending): discard the word. isPCWrite=1; data=redirect_target if redirect_valid, else the pending target. Clear pending; inst_valid=0; stay in FETCH.
  - imem_ready=1, no redirect, stall=0: register inst=imem_rdata, inst_pc=PC, inst_valid=1. isPCWrite=1, data=PC+4; stay in FETCH.
  - imem_ready=1, no redirect, stall=1: store the word and PC in the hold buffer. isPCWrite=0; go to HOLD.
- HOLD, imem_req=0:
  - redirect_valid=1: drop the buffer. isPCWrite=1, data=redirect_target; go to FETCH. Redirect beats stall release in the same cycle.
  - stall=0, no redirect: present the buffer with inst_valid=1. isPCWrite=1, data=PC+4; go to FETCH.
  - stall=1, no redirect: stay; isPCWrite=0.
- inst_valid is high for exactly one cycle per delivered word. inst and inst_pc hold their last values otherwise.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Alignment: bits [1:0] of data are always 2'b00; redirect_target[1:0] is ignored.
- Reset mid-fetch: the outstanding request is abandoned (imem_req drops immediately) and no inst_valid is produced.

Test Plan:
- Release reset, imem_ready=1 every cycle, stall=0:
  - imem_addr sequence is 3000, 3004, 3008.
  - inst_valid pulses each cycle with inst_pc matching.
  - isPCWrite=1 each edge.
- Set imem_ready=0 for 3 cycles at PC=3004:
  - isPCWrite=0 and imem_addr stays 3004 for those 3 cycles.
  - On ready, data=3008 and inst_pc=3004.
- Redirect to 0x4000 while a fetch at 3008 is waiting on imem_ready=0, then a second redirect to 0x5000, then ready:
  - The word is discarded and inst_valid stays 0.
  - data=5000; the next fetch address is 5000.
- stall=1 when ready returns at PC=300C:
  - FSM enters HOLD; imem_req=0; no PC write.
  - stall=0 two cycles later: inst_pc=300C delivered once and data=3010.
- In HOLD, stall release and redirect_valid=1 (target 0x6002) in the same cycle:
  - The buffer is dropped and inst_valid=0.
  - data=6000 (low bits masked).
- Wrap and reset:
  - Redirect to FFFF_FFFC, then a fetch completes: data=0.
  - Assert rst_n=0 mid-request: imem_req falls immediately and data=3000 with isPCWrite=1.
